// File: rtl/wb_arb_rr_pkg.sv
// Shared types and Wishbone B3 constants for the round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    // Cycle type identifier encodings
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extension encodings
    localparam logic [1:0] LINEAR = 2'b00;
    localparam logic [1:0] WRAP4  = 2'b01;
    localparam logic [1:0] WRAP8  = 2'b10;
    localparam logic [1:0] WRAP16 = 2'b11;

endpackage

// File: rtl/wb_arb_rr_if.sv
// Bus bundle between NUM_MASTERS Wishbone masters, the arbiter and one slave.
// Modport slave is the arbiter's view; modport master is the surrounding system.
interface wb_arb_rr_if #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    localparam int SW = DW / 8;

    // Master side
    logic [NUM_MASTERS*AW-1:0] m_adr_i;
    logic [NUM_MASTERS*DW-1:0] m_dat_i;
    logic [NUM_MASTERS*SW-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS*3-1:0]  m_cti_i;
    logic [NUM_MASTERS*2-1:0]  m_bte_i;
    logic [NUM_MASTERS*DW-1:0] m_dat_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic [NUM_MASTERS-1:0]    m_rty_o;

    // Slave side
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic          s_we_o;
    logic          s_cyc_o;
    logic          s_stb_o;
    logic [2:0]    s_cti_o;
    logic [1:0]    s_bte_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic          s_err_i;
    logic          s_rty_i;

    // Status
    logic [NUM_MASTERS-1:0] gnt_o;
    logic                   timeout_o;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output gnt_o, timeout_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  gnt_o, timeout_o
    );

endinterface

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester above the last grant wins,
// searching upward with wrap-around. Output is one-hot, or zero with no request.
module wb_arb_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_i,
    output logic [N-1:0] gnt_o
);

    int unsigned last_idx;
    int unsigned idx;
    logic        found;

    // Decode last grant index, then scan the N positions that follow it
    always_comb begin
        last_idx = 0;
        idx      = 0;
        found    = 1'b0;
        gnt_o    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (last_i[k]) last_idx = k;
        end
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (last_idx + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave.
// Grant is held for a whole cyc, so bursts are never split.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb_rr
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    wb_arb_rr_if.slave  bus
);

    localparam int N  = NUM_MASTERS;
    localparam int SW = DW / 8;
    localparam logic [N-1:0] LAST_RST = {1'b1, {(N-1){1'b0}}};

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   last_q, last_d;
    logic [N-1:0]   pick;
    logic [N-1:0]   err_route;
    logic           s_stb_raw;
    logic           to_hit;

    wb_arb_rr_pick #(.N(N)) u_pick (
        .req_i  (bus.m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Next state: grant on any cyc, release when the owner drops cyc
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = BUSY;
                    gnt_d   = pick;
                    last_d  = pick;
                end
            end
            BUSY: begin
                if (!(|(bus.m_cyc_i & gnt_q))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and last-grant registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Request/response mux; gnt_q is zero in IDLE so everything reads 0 there
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cyc_o = 1'b0;
        s_stb_raw   = 1'b0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack_o = '0;
        err_route   = '0;
        bus.m_rty_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt_q[k]) begin
                bus.s_adr_o           = bus.m_adr_i[k*AW +: AW];
                bus.s_dat_o           = bus.m_dat_i[k*DW +: DW];
                bus.s_sel_o           = bus.m_sel_i[k*SW +: SW];
                bus.s_we_o            = bus.m_we_i[k];
                bus.s_cyc_o           = bus.m_cyc_i[k];
                s_stb_raw             = bus.m_stb_i[k];
                bus.s_cti_o           = bus.m_cti_i[k*3 +: 3];
                bus.s_bte_o           = bus.m_bte_i[k*2 +: 2];
                bus.m_dat_o[k*DW +: DW] = bus.s_dat_i;
                bus.m_ack_o[k]        = bus.s_ack_i;
                err_route[k]          = bus.s_err_i;
                bus.m_rty_o[k]        = bus.s_rty_i;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign to_hit = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT));

    // Count stalled strobe cycles; any other cycle, or the timeout itself, clears
    always_comb begin
        cnt_d = '0;
        if ((state_q == BUSY) && !to_hit && s_stb_raw &&
            !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign bus.s_stb_o   = s_stb_raw & ~to_hit;
    assign bus.m_err_o   = err_route | (gnt_q & {N{to_hit}});
    assign bus.timeout_o = to_hit;
    assign bus.gnt_o     = gnt_q;

endmodule
